// File: rtl/alu_issue_arbiter_if.sv
// Request, branch-update and output handshake bundle for alu_issue_arbiter.
// The master side is the issue logic and ALU; the slave side is the arbiter.
interface alu_issue_arbiter_if #(
  parameter int BR_MASK_W = 20,
  parameter int PAYLOAD_W = 160
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [BR_MASK_W-1:0] req0_br_mask;
  logic [PAYLOAD_W-1:0] req0_payload;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [BR_MASK_W-1:0] req1_br_mask;
  logic [PAYLOAD_W-1:0] req1_payload;

  logic [BR_MASK_W-1:0] brupdate_resolve_mask;
  logic [BR_MASK_W-1:0] brupdate_mispredict_mask;
  logic                 flush;

  logic                 out_valid;
  logic                 out_ready;
  logic [BR_MASK_W-1:0] out_br_mask;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 out_src;

  modport master (
    output req0_valid, req0_br_mask, req0_payload,
    output req1_valid, req1_br_mask, req1_payload,
    output brupdate_resolve_mask, brupdate_mispredict_mask, flush,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_br_mask, out_payload, out_src
  );

  modport slave (
    input  req0_valid, req0_br_mask, req0_payload,
    input  req1_valid, req1_br_mask, req1_payload,
    input  brupdate_resolve_mask, brupdate_mispredict_mask, flush,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_br_mask, out_payload, out_src
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Two-port round-robin issue arbiter into a one-entry, branch-mask-tracking ALU slot.
// Define ALU_ISSUE_ARB_PERF_EN to add the perf_grant0/perf_grant1/perf_conflict counters.
module alu_issue_arbiter #(
  parameter int BR_MASK_W = 20,
  parameter int PAYLOAD_W = 160
) (
  input  logic                clock,
  input  logic                reset,
  alu_issue_arbiter_if.slave  bus
`ifdef ALU_ISSUE_ARB_PERF_EN
  ,
  output logic [31:0]         perf_grant0,
  output logic [31:0]         perf_grant1,
  output logic [31:0]         perf_conflict
`endif
);

  typedef struct packed {
    logic [BR_MASK_W-1:0] br_mask;
    logic [PAYLOAD_W-1:0] payload;
    logic                 src;
  } entry_t;

  logic   valid_q, valid_d;
  logic   rr_q, rr_d;
  entry_t entry_q, entry_d;

  logic held_hit, held_kill, slot_free;
  logic dead0, dead1, live0, live1;
  logic grant0, grant1, any_grant;

  // Kill and liveness: a mispredict on any set mask bit wins over a same-cycle resolve.
  always_comb begin
    held_hit  = |(entry_q.br_mask & bus.brupdate_mispredict_mask);
    held_kill = valid_q & (bus.flush | held_hit);
    slot_free = ~valid_q | bus.out_ready | held_kill;

    dead0 = bus.flush | (|(bus.req0_br_mask & bus.brupdate_mispredict_mask));
    dead1 = bus.flush | (|(bus.req1_br_mask & bus.brupdate_mispredict_mask));
    live0 = bus.req0_valid & ~dead0 & ~reset;
    live1 = bus.req1_valid & ~dead1 & ~reset;

    grant0    = slot_free & live0 & (~live1 | ~rr_q);
    grant1    = slot_free & live1 & (~live0 |  rr_q);
    any_grant = grant0 | grant1;
  end

  assign bus.out_valid   = valid_q & ~bus.flush & ~held_hit;
  assign bus.out_br_mask = entry_q.br_mask;
  assign bus.out_payload = entry_q.payload;
  assign bus.out_src     = entry_q.src;

  // Dead requests are consumed silently; no handshake at all while reset is high.
  assign bus.req0_ready = ~reset & ((bus.req0_valid & dead0) | grant0);
  assign bus.req1_ready = ~reset & ((bus.req1_valid & dead1) | grant1);

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    valid_d         = valid_q;
    rr_d            = rr_q;
    entry_d         = entry_q;
    entry_d.br_mask = entry_q.br_mask & ~bus.brupdate_resolve_mask;

    if (any_grant) begin
      valid_d         = 1'b1;
      rr_d            = grant0;
      entry_d.src     = grant1;
      entry_d.payload = grant0 ? bus.req0_payload : bus.req1_payload;
      entry_d.br_mask = (grant0 ? bus.req0_br_mask : bus.req1_br_mask)
                        & ~bus.brupdate_resolve_mask;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  // NOTE: the payload/mask register is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clock) begin
    entry_q <= entry_d;
  end

`ifdef ALU_ISSUE_ARB_PERF_EN
  logic both_live, nonrr_lost, conflict;

  always_comb begin
    both_live  = live0 & live1;
    nonrr_lost = rr_q ? ~grant0 : ~grant1;
    conflict   = both_live & (~any_grant | nonrr_lost);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      perf_grant0   <= perf_grant0   + 32'(grant0);
      perf_grant1   <= perf_grant1   + 32'(grant1);
      perf_conflict <= perf_conflict + 32'(conflict);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: expected output transactions are queued by the
// stimulus and checked by an independent monitor at every output handshake.
module tb_alu_issue_arbiter;
  localparam int BMW = 20;
  localparam int PLW = 160;

  logic clock = 1'b0;
  logic reset;

  alu_issue_arbiter_if #(.BR_MASK_W(BMW), .PAYLOAD_W(PLW)) bus ();

`ifdef ALU_ISSUE_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  alu_issue_arbiter #(.BR_MASK_W(BMW), .PAYLOAD_W(PLW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_ISSUE_ARB_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [BMW-1:0] mask;
    logic [PLW-1:0] payload;
    logic           src;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PLW-1:0] pl(input logic [7:0] tag);
    return {20{tag}};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid               = 1'b0;
    bus.req0_br_mask             = '0;
    bus.req0_payload             = '0;
    bus.req1_valid               = 1'b0;
    bus.req1_br_mask             = '0;
    bus.req1_payload             = '0;
    bus.brupdate_resolve_mask    = '0;
    bus.brupdate_mispredict_mask = '0;
    bus.flush                    = 1'b0;
  endtask

  task automatic drive0(input logic v, input logic [BMW-1:0] m, input logic [PLW-1:0] p);
    bus.req0_valid   = v;
    bus.req0_br_mask = m;
    bus.req0_payload = p;
  endtask

  task automatic drive1(input logic v, input logic [BMW-1:0] m, input logic [PLW-1:0] p);
    bus.req1_valid   = v;
    bus.req1_br_mask = m;
    bus.req1_payload = p;
  endtask

  task automatic expect_out(input logic [BMW-1:0] m, input logic [PLW-1:0] p, input logic s);
    exp_t e;
    e.mask    = m;
    e.payload = p;
    e.src     = s;
    sb_q.push_back(e);
  endtask

  // Monitor: every accepted output must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got src %0d payload %0h, expected no transaction",
                   bus.out_src, bus.out_payload);
        end else begin
          e = sb_q.pop_front();
          check("sb_br_mask", 256'(bus.out_br_mask), 256'(e.mask));
          check("sb_payload", 256'(bus.out_payload), 256'(e.payload));
          check("sb_src",     256'(bus.out_src),     256'(e.src));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n0, n1, g;
    n0 = 0;
    n1 = 0;

    // Reset: no handshakes while held, empty slot afterwards.
    reset = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    step();
    drive0(1'b1, '0, pl(8'h01));
    drive1(1'b1, '0, pl(8'h02));
    #1;
    check("rst_ready0", 256'(bus.req0_ready), 256'(0));
    check("rst_ready1", 256'(bus.req1_ready), 256'(0));
    step();
    reset = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));

    // Both requesters live with out_ready high: grants alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      drive0(1'b1, 20'h00001, pl(8'h10 + 8'(n0)));
      drive1(1'b1, 20'h00002, pl(8'h20 + 8'(n1)));
      #1;
      g = k % 2;
      check("rr_ready0", 256'(bus.req0_ready), 256'(g == 0));
      check("rr_ready1", 256'(bus.req1_ready), 256'(g == 1));
      if (g == 0) begin
        expect_out(20'h00001, pl(8'h10 + 8'(n0)), 1'b0);
        n0++;
      end else begin
        expect_out(20'h00002, pl(8'h20 + 8'(n1)), 1'b1);
        n1++;
      end
      step();
    end
    idle();
    step();

    // Held entry killed by mispredict; live req0 refills the slot the same cycle.
    bus.out_ready = 1'b0;
    drive0(1'b1, 20'h00004, pl(8'h30));
    #1;
    check("b_load_ready0", 256'(bus.req0_ready), 256'(1));
    step();
    drive0(1'b1, 20'h00000, pl(8'h31));
    bus.brupdate_mispredict_mask = 20'h00004;
    #1;
    check("b_kill_out_valid", 256'(bus.out_valid), 256'(0));
    check("b_kill_regrant", 256'(bus.req0_ready), 256'(1));
    expect_out(20'h00000, pl(8'h31), 1'b0);
    step();
    idle();
    bus.out_ready = 1'b1;
    #1;
    check("b_refill_valid", 256'(bus.out_valid), 256'(1));
    step();

    // Resolve while holding clears the bit before the handshake.
    bus.out_ready = 1'b0;
    drive1(1'b1, 20'h00006, pl(8'h40));
    #1;
    check("c_load_ready1", 256'(bus.req1_ready), 256'(1));
    step();
    idle();
    bus.brupdate_resolve_mask = 20'h00002;
    #1;
    check("c_mask_before", 256'(bus.out_br_mask), 256'(20'h00006));
    step();
    idle();
    bus.out_ready = 1'b1;
    expect_out(20'h00004, pl(8'h40), 1'b1);
    #1;
    check("c_out_valid", 256'(bus.out_valid), 256'(1));
    step();

    // Dead request with the slot full: discarded, output and rr untouched.
    bus.out_ready = 1'b0;
    drive0(1'b1, 20'h00000, pl(8'h50));
    expect_out(20'h00000, pl(8'h50), 1'b0);
    #1;
    check("d_load_ready0", 256'(bus.req0_ready), 256'(1));
    step();
    idle();
    drive1(1'b1, 20'h00010, pl(8'h51));
    bus.brupdate_mispredict_mask = 20'h00010;
    #1;
    check("d_dead_ready1", 256'(bus.req1_ready), 256'(1));
    check("d_out_valid_kept", 256'(bus.out_valid), 256'(1));
    step();
    idle();
    drive0(1'b1, 20'h00000, pl(8'h52));
    drive1(1'b1, 20'h00000, pl(8'h53));
    bus.out_ready = 1'b1;
    #1;
    check("d_rr_kept_ready1", 256'(bus.req1_ready), 256'(1));
    check("d_rr_kept_ready0", 256'(bus.req0_ready), 256'(0));
    expect_out(20'h00000, pl(8'h53), 1'b1);
    step();
    idle();
    step();

    // Resolve at grant, then resolve and mispredict on the same bit: mispredict wins.
    bus.out_ready = 1'b0;
    drive0(1'b1, 20'h00009, pl(8'h60));
    bus.brupdate_resolve_mask = 20'h00001;
    #1;
    check("e_load_ready0", 256'(bus.req0_ready), 256'(1));
    step();
    idle();
    #1;
    check("e_grant_resolved", 256'(bus.out_br_mask), 256'(20'h00008));
    bus.brupdate_resolve_mask    = 20'h00008;
    bus.brupdate_mispredict_mask = 20'h00008;
    #1;
    check("e_mispredict_wins", 256'(bus.out_valid), 256'(0));
    step();
    idle();
    #1;
    check("e_entry_dropped", 256'(bus.out_valid), 256'(0));
    step();

    // Flush with an entry held and both requests valid.
    drive0(1'b1, 20'h00000, pl(8'h70));
    #1;
    check("f_load_ready0", 256'(bus.req0_ready), 256'(1));
    step();
    drive0(1'b1, 20'h00000, pl(8'h71));
    drive1(1'b1, 20'h00000, pl(8'h72));
    bus.flush = 1'b1;
    #1;
    check("f_flush_ready0", 256'(bus.req0_ready), 256'(1));
    check("f_flush_ready1", 256'(bus.req1_ready), 256'(1));
    check("f_flush_out_valid", 256'(bus.out_valid), 256'(0));
    step();
    idle();
    #1;
    check("f_flush_cleared", 256'(bus.out_valid), 256'(0));
    step();

    // Reset mid-hold: entry discarded, rr back to port 0.
    drive0(1'b1, 20'h00000, pl(8'h73));
    #1;
    check("f_hold_ready0", 256'(bus.req0_ready), 256'(1));
    step();
    idle();
    #1;
    check("f_hold_valid", 256'(bus.out_valid), 256'(1));
    reset = 1'b1;
    drive0(1'b1, 20'h00000, pl(8'h74));
    #1;
    check("f_rst_ready0", 256'(bus.req0_ready), 256'(0));
    step();
    reset = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    drive0(1'b1, 20'h00000, pl(8'h75));
    drive1(1'b1, 20'h00000, pl(8'h76));
    #1;
    check("f_rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("f_rst_rr_ready0", 256'(bus.req0_ready), 256'(1));
    check("f_rst_rr_ready1", 256'(bus.req1_ready), 256'(0));
    expect_out(20'h00000, pl(8'h75), 1'b0);
    step();
    idle();
    step();
    step();

    check("sb_drained", 256'(sb_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
